mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute ALU. Consumes the ALU result
//  (effective address for LDB/LDW/STB/STW, final value for all other opcodes), performs
//  byte/word loads and stores over a valid/ready data-memory port, and presents one
//  registered writeback record per instruction. Stalls upstream while a memory access is open.
// PARAMETERS
//  ARCH_BITS      32  datapath width; fixed at 32 (byte lanes assume 4 bytes/word)
//  REG_ADDR_BITS  5   destination register index width
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  in_valid       in   1          execute-stage instruction present
//  in_ready       out  1          stage can accept; 1 only in IDLE
//  in_opcode      in   7          opcode (proc.OPCODE_* encoding)
//  in_alu_res     in   ARCH_BITS  ALU result / effective address
//  in_store_data  in   ARCH_BITS  rs2 value for stores
//  in_rd          in   REG_ADDR   destination register
//  in_wb_en       in   1          instruction writes rd
//  mem_req_valid  out  1          request to data memory
//  mem_req_ready  in   1          memory accepts request
//  mem_req_we     out  1          1=store, 0=load
//  mem_req_addr   out  ARCH_BITS  word-aligned address ({addr[31:2],2'b00})
//  mem_req_be     out  4          byte enables (stores); 4'hF on loads
//  mem_req_wdata  out  ARCH_BITS  store data, lane-positioned
//  mem_resp_valid in   1          load data returned (1-cycle pulse)
//  mem_resp_rdata in   ARCH_BITS  load data word
//  wb_valid       out  1          writeback record valid (1-cycle pulse)
//  wb_en          out  1          write rd
//  wb_rd          out  REG_ADDR   destination register
//  wb_data        out  ARCH_BITS  value to write
//  misalign       out  1          1-cycle pulse: LDW/STW with addr[1:0]!=0
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; mem_req_valid, wb_valid, wb_en, misalign=0; all data regs 0.
//  - FSM IDLE/REQ/WAIT. Accept = in_valid & in_ready.
//  - IDLE, accept non-memory opcode: next cycle wb_valid=1, wb_data=in_alu_res, wb_rd=in_rd,
//    wb_en=in_wb_en. Latency 1; back-to-back accepts every cycle.
//  - IDLE, accept LDB/LDW/STB/STW: latch address/data/rd/opcode -> REQ. misalign pulses same
//    cycle as the latch (registered), access still proceeds with low address bits dropped.
//  - REQ: mem_req_valid=1, fields stable until mem_req_ready. On handshake: store -> IDLE with
//    wb_valid=1, wb_en=0 next cycle; load -> WAIT.
//  - WAIT: on mem_resp_valid -> IDLE; next cycle wb_valid=1, wb_en=1,
//    LDW: wb_data=rdata; LDB: byte lane addr[1:0] (little-endian) sign-extended to 32 bits.
//    Response earliest one cycle after handshake; resp in same cycle as handshake is illegal.
//  - STB: mem_req_be=4'b0001<<addr[1:0]; wdata = store byte replicated in all 4 lanes.
//    STW: be=4'hF, wdata=in_store_data.
//  - in_ready=0 in REQ and WAIT; upstream holds its inputs. Min load latency accept->wb = 3 cycles.
//  - mem_resp_valid outside WAIT ignored. Unknown opcodes treated as non-memory pass-through.
//  - rst mid-access: abandon request immediately, no wb_valid for it; memory side must
//    tolerate a dropped request; late response then ignored (IDLE).
// STRUCTURE
//  - Opcode constants, ARCH_BITS, REG_ADDR_BITS from shared proc package; add stage-state
//    localparams (IDLE/REQ/WAIT) there only if shared with other stages.
//  - One sub-module natural: mem_byte_lane (store lane positioning + load extract/sign-extend),
//    purely combinational; FSM and registers stay in mem_stage.
// TESTING
//  - ADD, alu_res=32'h0000_0007, rd=3, wb_en=1 -> next cycle wb_valid, wb_data=7, wb_rd=3;
//    three consecutive ALU ops -> three consecutive wb_valid pulses, in_ready held 1.
//  - LDW addr 32'h100, ready=1 immediately, resp 2 cycles later rdata=32'hDEADBEEF ->
//    mem_req_addr=32'h100, be=4'hF, wb_data=32'hDEADBEEF; in_ready=0 throughout.
//  - LDB addr 32'h103, rdata=32'h80FF_0000 -> wb_data=32'hFFFF_FF80; addr 32'h101,
//    same rdata -> wb_data=32'h0000_0000.
//  - STB addr 32'h202, store_data=32'h0000_00AB, ready low 3 cycles -> req held stable,
//    addr=32'h200, be=4'b0100, wdata=32'hABABABAB; after handshake wb_valid=1, wb_en=0.
//  - STW addr 32'h305 -> misalign pulse, addr=32'h304, be=4'hF; resp pulse while IDLE ignored.
//  - rst asserted in WAIT -> next cycle IDLE, in_ready=1, no wb_valid; later resp ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared datapath widths and opcode encodings for the processor stages
package mem_stage_pkg;
   localparam int ARCH_BITS     = 32;
   localparam int REG_ADDR_BITS = 5;
   localparam logic [6:0] OPCODE_ADD = 7'h00;
   localparam logic [6:0] OPCODE_SUB = 7'h01;
   localparam logic [6:0] OPCODE_LDB = 7'h10;
   localparam logic [6:0] OPCODE_LDW = 7'h11;
   localparam logic [6:0] OPCODE_STB = 7'h12;
   localparam logic [6:0] OPCODE_STW = 7'h13;
   function automatic logic is_mem_op(input logic [6:0] op);
      return op == OPCODE_LDB || op == OPCODE_LDW || op == OPCODE_STB || op == OPCODE_STW;
   endfunction
endpackage

// File: rtl/mem_stage_lane.sv
// mem_byte_lane: store byte-lane positioning and load byte extraction with sign extension
module mem_byte_lane
   import mem_stage_pkg::*;
(
   input  logic [1:0]           addr_lo_i,
   input  logic                 byte_i,
   input  logic [ARCH_BITS-1:0] store_data_i,
   input  logic [ARCH_BITS-1:0] rdata_i,
   output logic [3:0]           be_o,
   output logic [ARCH_BITS-1:0] wdata_o,
   output logic [ARCH_BITS-1:0] load_data_o
);
   logic [7:0] ld_byte;
   // little-endian lane select; a byte store is replicated so any lane sees it
   always_comb begin
      ld_byte     = 8'(rdata_i >> {addr_lo_i, 3'b000});
      be_o        = byte_i ? 4'(4'b0001 << addr_lo_i) : 4'hF;
      wdata_o     = byte_i ? {4{store_data_i[7:0]}} : store_data_i;
      load_data_o = byte_i ? {{24{ld_byte[7]}}, ld_byte} : rdata_i;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with byte/word loads and stores and a registered writeback record
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_opcode,
   input  logic [ARCH_BITS-1:0]     in_alu_res,
   input  logic [ARCH_BITS-1:0]     in_store_data,
   input  logic [REG_ADDR_BITS-1:0] in_rd,
   input  logic                     in_wb_en,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_we,
   output logic [ARCH_BITS-1:0]     mem_req_addr,
   output logic [3:0]               mem_req_be,
   output logic [ARCH_BITS-1:0]     mem_req_wdata,
   input  logic                     mem_resp_valid,
   input  logic [ARCH_BITS-1:0]     mem_resp_rdata,
   output logic                     wb_valid,
   output logic                     wb_en,
   output logic [REG_ADDR_BITS-1:0] wb_rd,
   output logic [ARCH_BITS-1:0]     wb_data,
   output logic                     misalign
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
   state_e                   state_q, state_d;
   logic [ARCH_BITS-1:0]     addr_q, addr_d, sdata_q, sdata_d, wb_data_q, wb_data_d;
   logic [REG_ADDR_BITS-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
   logic [6:0]               op_q, op_d;
   logic                     wb_valid_q, wb_valid_d, wb_en_q, wb_en_d, misalign_q, misalign_d;
   logic                     accept, is_byte, is_store;
   logic [3:0]               lane_be;
   logic [ARCH_BITS-1:0]     lane_wdata, lane_load;

   assign accept        = in_valid & in_ready;
   assign is_byte       = op_q == OPCODE_LDB || op_q == OPCODE_STB;
   assign is_store      = op_q == OPCODE_STB || op_q == OPCODE_STW;
   assign in_ready      = state_q == IDLE;
   // reset drops an open request in the same cycle rather than one cycle later
   assign mem_req_valid = state_q == REQ && !rst;
   assign mem_req_we    = is_store;
   assign mem_req_addr  = {addr_q[ARCH_BITS-1:2], 2'b00};
   assign mem_req_be    = is_store ? lane_be : 4'hF;
   assign mem_req_wdata = lane_wdata;
   assign wb_valid      = wb_valid_q;
   assign wb_en         = wb_en_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;
   assign misalign      = misalign_q;

   mem_byte_lane u_lane (
      .addr_lo_i    (addr_q[1:0]),
      .byte_i       (is_byte),
      .store_data_i (sdata_q),
      .rdata_i      (mem_resp_rdata),
      .be_o         (lane_be),
      .wdata_o      (lane_wdata),
      .load_data_o  (lane_load)
   );

   // next state: pass-through ops write back next cycle; memory ops go through REQ (and WAIT for loads)
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      rd_d       = rd_q;
      op_d       = op_q;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      misalign_d = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            if (is_mem_op(in_opcode)) begin
               state_d    = REQ;
               addr_d     = in_alu_res;
               sdata_d    = in_store_data;
               rd_d       = in_rd;
               op_d       = in_opcode;
               misalign_d = (in_opcode == OPCODE_LDW || in_opcode == OPCODE_STW) && in_alu_res[1:0] != 2'b00;
            end else begin
               wb_valid_d = 1'b1;
               wb_en_d    = in_wb_en;
               wb_rd_d    = in_rd;
               wb_data_d  = in_alu_res;
            end
         end
         REQ: if (mem_req_ready) begin
            state_d    = is_store ? IDLE : WAIT;
            wb_valid_d = is_store;
         end
         WAIT: if (mem_resp_valid) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_en_d    = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = lane_load;
         end
         default: state_d = IDLE;
      endcase
   end

   // state and record registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sdata_q    <= '0;
         rd_q       <= '0;
         op_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         rd_q       <= rd_d;
         op_q       <= op_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a word-array memory model
module tb_mem_stage;
   import mem_stage_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_wb_en = 1'b0;
   logic [6:0]  in_opcode = '0;
   logic [31:0] in_alu_res = '0, in_store_data = '0;
   logic [4:0]  in_rd = '0;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_rdata = '0;
   logic        wb_valid, wb_en, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] mem [256];
   int          checks = 0, errors = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_rd(in_rd), .in_wb_en(in_wb_en),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .wb_valid(wb_valid),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one instruction from accept to writeback; rdly = cycles memory holds ready low, pdly = handshake-to-response cycles
   task automatic run_op(input logic [6:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic wben, input int rdly, input int pdly);
      logic        is_mem, is_st, is_b, exp_mis;
      logic [31:0] word, b, exp_data, exp_be, exp_wdata;
      int          off, idx;
      is_mem    = op == OPCODE_LDB || op == OPCODE_LDW || op == OPCODE_STB || op == OPCODE_STW;
      is_st     = op == OPCODE_STB || op == OPCODE_STW;
      is_b      = op == OPCODE_LDB || op == OPCODE_STB;
      off       = int'(alu % 4);
      idx       = int'((alu / 4) % 256);
      exp_mis   = (op == OPCODE_LDW || op == OPCODE_STW) && off != 0;
      exp_be    = (is_st && is_b) ? (32'd1 << off) : 32'hF;
      exp_wdata = is_b ? (sd % 256) * 32'h0101_0101 : sd;
      chk("ready_before", in_ready, 1);
      in_valid = 1'b1; in_opcode = op; in_alu_res = alu; in_store_data = sd; in_rd = rd; in_wb_en = wben;
      @(negedge clk);
      in_valid = 1'b0;
      if (!is_mem) begin
         chk("alu_wb_valid", wb_valid, 1);
         chk("alu_wb_en", wb_en, wben);
         chk("alu_wb_rd", wb_rd, rd);
         chk("alu_wb_data", wb_data, alu);
         chk("alu_ready", in_ready, 1);
      end else begin
         for (int c = 0; c <= rdly; c++) begin
            chk("misalign", misalign, c == 0 ? exp_mis : 1'b0);
            chk("req_valid", mem_req_valid, 1);
            chk("req_we", mem_req_we, is_st);
            chk("req_addr", mem_req_addr, alu - off);
            chk("req_be", mem_req_be, exp_be);
            if (is_st) chk("req_wdata", mem_req_wdata, exp_wdata);
            chk("req_ready_low", in_ready, 0);
            chk("req_no_wb", wb_valid, 0);
            if (c == rdly) mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
         end
         if (is_st) begin
            word = mem[idx];
            if (is_b) word[8*off +: 8] = sd[7:0];
            else word = sd;
            mem[idx] = word;
            chk("st_wb_valid", wb_valid, 1);
            chk("st_wb_en", wb_en, 0);
            chk("st_ready", in_ready, 1);
         end else begin
            word = mem[idx];
            b = (word >> (8 * off)) % 256;
            exp_data = (op == OPCODE_LDW) ? word : (b >= 128 ? b + 32'hFFFF_FF00 : b);
            for (int c = 1; c < pdly; c++) begin
               chk("wait_ready_low", in_ready, 0);
               chk("wait_no_wb", wb_valid, 0);
               chk("wait_no_req", mem_req_valid, 0);
               @(negedge clk);
            end
            mem_resp_valid = 1'b1; mem_resp_rdata = word;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
            chk("ld_wb_valid", wb_valid, 1);
            chk("ld_wb_en", wb_en, 1);
            chk("ld_wb_rd", wb_rd, rd);
            chk("ld_wb_data", wb_data, exp_data);
            chk("ld_ready", in_ready, 1);
         end
      end
   endtask

   initial begin
      logic [6:0] ops [7];
      logic [6:0] op;
      ops = '{OPCODE_ADD, OPCODE_SUB, 7'h7F, OPCODE_LDB, OPCODE_LDW, OPCODE_STB, OPCODE_STW};
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", in_ready, 1);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_wb_data", wb_data, 0);
      run_op(OPCODE_ADD, 32'h0000_0007, 32'h0, 5'd3, 1'b1, 0, 1);
      chk("add_const", wb_data, 32'h7);
      run_op(OPCODE_SUB, 32'h1234_5678, 32'h0, 5'd4, 1'b1, 0, 1);
      run_op(7'h7F, 32'hCAFE_F00D, 32'h0, 5'd9, 1'b0, 0, 1);
      mem[32'h100 / 4] = 32'hDEAD_BEEF;
      run_op(OPCODE_LDW, 32'h100, 32'h0, 5'd5, 1'b1, 0, 2);
      chk("ldw_const", wb_data, 32'hDEAD_BEEF);
      mem[32'h100 / 4] = 32'h80FF_0000;
      run_op(OPCODE_LDB, 32'h103, 32'h0, 5'd6, 1'b1, 0, 1);
      chk("ldb103_const", wb_data, 32'hFFFF_FF80);
      run_op(OPCODE_LDB, 32'h101, 32'h0, 5'd7, 1'b1, 1, 3);
      chk("ldb101_const", wb_data, 32'h0);
      run_op(OPCODE_STB, 32'h202, 32'h0000_00AB, 5'd0, 1'b0, 3, 1);
      run_op(OPCODE_STW, 32'h305, 32'h1357_9BDF, 5'd0, 1'b0, 0, 1);
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("idle_resp_no_wb", wb_valid, 0);
      chk("idle_resp_ready", in_ready, 1);
      chk("idle_resp_no_req", mem_req_valid, 0);
      in_valid = 1'b1; in_opcode = OPCODE_LDW; in_alu_res = 32'h100; in_rd = 5'd8;
      @(negedge clk);
      in_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("wait_before_rst", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_wait_ready", in_ready, 1);
      chk("rst_wait_no_wb", wb_valid, 0);
      chk("rst_wait_no_req", mem_req_valid, 0);
      mem_resp_valid = 1'b1;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("late_resp_no_wb", wb_valid, 0);
      chk("late_resp_ready", in_ready, 1);
      for (int i = 0; i < 80; i++) begin
         op = ops[$urandom_range(0, 6)];
         run_op(op, is_mem_op(op) ? 32'($urandom_range(0, 1023)) : $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 3));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
